// File: rtl/vertex_feeder.sv
// Vertex feeder: reads one object's vertices from memory, sends them to the projector
// one at a time, and assembles the projected results into triangles.
module vertex_feeder #(
  parameter int NUM_VERTS = 36,
  parameter int ADDR_W    = 8,
  parameter int MEM_LAT   = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [127:0]      mem_data_in,
  output logic [127:0]      proj_coor_out,
  output logic              proj_valid_out,
  output logic              proj_obj_done_out,
  input  logic [26:0]       proj_coor_in,
  input  logic              proj_valid_in,
  output logic [80:0]       tri_out,
  output logic              tri_valid_out,
  input  logic              tri_ready_in,
  output logic              busy_out,
  output logic              obj_done_out,
  output logic              err_out
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;

  localparam logic [7:0] LAST_VI  = 8'(NUM_VERTS - 1);
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  logic [2:0]  state;
  logic [7:0]  vi;
  logic [1:0]  slot;
  logic [2:0]  lat_cnt;
  logic [95:0] req;

  // The low word of each memory entry carries nothing.
  logic unused_mem_bits;
  assign unused_mem_bits = ^mem_data_in[31:0];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      vi           <= '0;
      slot         <= '0;
      lat_cnt      <= '0;
      req          <= '0;
      mem_addr_out <= '0;
      tri_out      <= '0;
      obj_done_out <= 1'b0;
      err_out      <= 1'b0;
    end else begin
      obj_done_out <= 1'b0;
      // A result with no request outstanding is dropped, but remembered.
      if (proj_valid_in && state != WAIT) err_out <= 1'b1;
      case (state)
        IDLE: if (start_in) begin
          vi           <= '0;
          slot         <= '0;
          lat_cnt      <= '0;
          mem_addr_out <= '0;
          state        <= FETCH;
        end
        FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            req   <= mem_data_in[127:32];
            state <= ISSUE;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: if (proj_valid_in) begin
          case (slot)
            2'd0:    tri_out[80:54] <= proj_coor_in;
            2'd1:    tri_out[53:27] <= proj_coor_in;
            default: tri_out[26:0]  <= proj_coor_in;
          endcase
          if (slot != 2'd2) begin
            slot         <= slot + 2'd1;
            vi           <= vi + 8'd1;
            mem_addr_out <= mem_addr_out + 1'b1;
            lat_cnt      <= '0;
            state        <= FETCH;
          end else begin
            state <= EMIT;
          end
        end
        EMIT: if (tri_ready_in) begin
          if (vi != LAST_VI) begin
            slot         <= '0;
            vi           <= vi + 8'd1;
            mem_addr_out <= mem_addr_out + 1'b1;
            lat_cnt      <= '0;
            state        <= FETCH;
          end else begin
            obj_done_out <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign proj_coor_out     = {req, 32'd0};
  assign proj_valid_out    = (state == ISSUE);
  assign proj_obj_done_out = (state == ISSUE) && (vi == LAST_VI);
  assign tri_valid_out     = (state == EMIT);
  assign busy_out          = (state != IDLE);

endmodule

// File: tb/tb_vertex_feeder.sv
// Randomized bench for vertex_feeder: a memory model, a projector model with variable
// reply delay, and a queue-based reference of expected requests, triangles and done pulses.
module tb_vertex_feeder;
  localparam int NV = 6;
  localparam int AW = 8;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst_in, start_in;
  logic [AW-1:0] mem_addr_out;
  logic [127:0]  mem_data_in;
  logic [127:0]  proj_coor_out;
  logic          proj_valid_out, proj_obj_done_out;
  logic [26:0]   proj_coor_in;
  logic          proj_valid_in;
  logic [80:0]   tri_out;
  logic          tri_valid_out, tri_ready_in;
  logic          busy_out, obj_done_out, err_out;

  vertex_feeder #(.NUM_VERTS(NV), .ADDR_W(AW), .MEM_LAT(ML)) u_dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
    .proj_coor_out(proj_coor_out), .proj_valid_out(proj_valid_out),
    .proj_obj_done_out(proj_obj_done_out), .proj_coor_in(proj_coor_in),
    .proj_valid_in(proj_valid_in), .tri_out(tri_out), .tri_valid_out(tri_valid_out),
    .tri_ready_in(tri_ready_in), .busy_out(busy_out), .obj_done_out(obj_done_out),
    .err_out(err_out));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Memory: data is valid only once the address has been held for ML cycles.
  logic [127:0]  mem [0:255];
  logic [AW-1:0] ah [0:6];
  logic          mem_ok;

  always @(posedge clk) begin
    for (int i = 6; i > 0; i--) ah[i] <= ah[i-1];
    ah[0] <= mem_addr_out;
  end

  always_comb begin
    mem_ok = 1'b1;
    for (int i = 0; i < ML - 1; i++)
      if (ah[i] !== mem_addr_out) mem_ok = 1'b0;
    mem_data_in = mem_ok ? mem[mem_addr_out] : {4{32'hDEADBEEF}};
  end

  // Reference state shared between the stimulus and the projector/monitor process.
  int          req_idx, tri_idx;
  int          fixed_delay;
  bit          obj_fixed;
  bit          pending, exp_done, done_seen, held_v, prev_pv;
  bit          inject, injected;
  int          cnt;
  logic [26:0] next_resp;
  logic [26:0] rq [$];
  logic [127:0] last_req;
  logic [80:0]  held;

  always @(negedge clk) begin
    if (!rst_in) begin
      proj_valid_in = 1'b0;
      pending = 0; exp_done = 0; held_v = 0; prev_pv = 0;
      rq.delete();
    end else begin
      proj_valid_in = 1'b0;
      if (obj_done_out || exp_done) chk("obj_done", obj_done_out, exp_done);
      if (obj_done_out) done_seen = 1;
      exp_done = 0;
      if (tri_valid_out) begin
        if (tri_ready_in) begin
          chk("tri_q_depth", rq.size() >= 3, 1);
          if (rq.size() >= 3) begin
            chk("tri", tri_out, {rq[0], rq[1], rq[2]});
            void'(rq.pop_front()); void'(rq.pop_front()); void'(rq.pop_front());
          end
          held_v = 0;
          if (tri_idx == NV/3 - 1) exp_done = 1;
          tri_idx++;
        end else begin
          if (held_v) chk("tri_hold", tri_out, held);
          held = tri_out; held_v = 1;
          chk("pv_during_emit", proj_valid_out, 0);
        end
      end
      if (pending) begin
        if (cnt == 0) begin
          chk("req_hold", proj_coor_out, last_req);
          proj_valid_in = 1'b1;
          proj_coor_in = next_resp;
          rq.push_back(next_resp);
          pending = 0;
        end else cnt--;
      end else if (inject && busy_out && !proj_valid_out && !tri_valid_out) begin
        proj_valid_in = 1'b1;
        proj_coor_in = 27'h7FFFFFF;
        inject = 0; injected = 1;
      end
      if (proj_valid_out) begin
        chk("pv_back_to_back", prev_pv, 0);
        chk("one_outstanding", pending, 0);
        chk("req_addr", mem_addr_out, req_idx);
        last_req = {mem[req_idx][127:32], 32'd0};
        chk("req_coor", proj_coor_out, last_req);
        chk("req_last", proj_obj_done_out, req_idx == NV - 1);
        next_resp = obj_fixed ? {9'(10 + req_idx), 9'(20 + req_idx), 9'(30 + req_idx)}
                              : 27'($urandom);
        cnt = (fixed_delay > 0 ? fixed_delay : int'($urandom_range(1, 6))) - 1;
        pending = 1;
        req_idx++;
      end
      prev_pv = proj_valid_out;
    end
  end

  task automatic start_obj(input bit fixed_vals, input int dly);
    for (int i = 0; i < NV; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    obj_fixed = fixed_vals; fixed_delay = dly;
    req_idx = 0; tri_idx = 0; done_seen = 0;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("obj_done_seen", done_seen, 1);
    chk("req_count", req_idx, NV);
    @(negedge clk);
    chk("idle_after_obj", busy_out, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_pv"}, proj_valid_out, 0);
    chk({tag, "_pdone"}, proj_obj_done_out, 0);
    chk({tag, "_tv"}, tri_valid_out, 0);
    chk({tag, "_addr"}, mem_addr_out, 0);
    chk({tag, "_tri"}, tri_out, 0);
    chk({tag, "_coor"}, proj_coor_out, 0);
    chk({tag, "_err"}, err_out, 0);
    chk({tag, "_done"}, obj_done_out, 0);
  endtask

  initial begin
    int n;
    rst_in = 1'b0; start_in = 1'b0; tri_ready_in = 1'b1;
    proj_valid_in = 1'b0; proj_coor_in = '0;
    inject = 0; injected = 0; fixed_delay = 5; obj_fixed = 1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_in = 1'b1;
    repeat (2) @(negedge clk);

    // Object 0: fixed projector values, 5-cycle replies, sink always ready.
    start_obj(1, 5);
    wait_done(400);

    // Object 1: stalled sink at the first triangle, and a stray start during WAIT.
    tri_ready_in = 1'b0;
    start_obj(0, 5);
    n = 0;
    while (!(pending && !proj_valid_out) && n < 100) begin @(negedge clk); n++; end
    chk("wait_for_wait", pending, 1);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    n = 0;
    while (!tri_valid_out && n < 200) begin @(negedge clk); n++; end
    chk("wait_for_emit", tri_valid_out, 1);
    n = req_idx;
    repeat (20) @(negedge clk);
    chk("no_req_while_stalled", req_idx, n);
    tri_ready_in = 1'b1;
    wait_done(400);
    chk("err_clean", err_out, 0);

    // Object 2: immediate replies plus a spurious result during FETCH.
    start_obj(0, 1);
    inject = 1;
    wait_done(400);
    chk("inject_done", injected, 1);
    chk("err_sticky", err_out, 1);
    repeat (3) @(negedge clk);
    chk("err_held", err_out, 1);

    // Object 3: reset in the second WAIT, then a clean restart.
    start_obj(0, 5);
    n = 0;
    while (!(req_idx == 2 && pending && !proj_valid_out) && n < 200) begin @(negedge clk); n++; end
    chk("wait_second_wait", req_idx, 2);
    rst_in = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    start_obj(0, 0);
    chk("restart_addr", mem_addr_out, 0);
    chk("restart_busy", busy_out, 1);
    wait_done(600);
    chk("err_after_reset", err_out, 0);

    // Object 4: fully random reply delays.
    start_obj(0, 0);
    wait_done(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vertex_feeder.md
VERTEX_FEEDER -- requirements
Module: vertex_feeder

Interface
REQ-001 SHALL have parameter NUM_VERTS, default 36, vertices per object; multiple of 3, range 3..255.
REQ-002 SHALL have parameter ADDR_W, default 8, vertex memory address width.
REQ-003 SHALL have parameter MEM_LAT, default 2, vertex memory read latency in cycles, range 1..7.
REQ-004 SHALL have port clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_in  input  1  one-cycle pulse that begins traversal of one object.
REQ-007 SHALL have port mem_addr_out  output  ADDR_W  vertex memory read address.
REQ-008 SHALL have port mem_data_in  input  128  memory word {x[127:96], y[95:64], z[63:32], unused[31:0]}, IEEE-754 single.
REQ-009 SHALL have port proj_coor_out  output  128  to projector coordinate input: [127:96] x, [95:64] y, [63:32] z, [31:0] zero.
REQ-010 SHALL have port proj_valid_out  output  1  projector request strobe.
REQ-011 SHALL have port proj_obj_done_out  output  1  marks the object's final vertex request.
REQ-012 SHALL have port proj_coor_in  input  27  projected result {x[26:18], y[17:9], z[8:0]}.
REQ-013 SHALL have port proj_valid_in  input  1  projected result strobe.
REQ-014 SHALL have port tri_out  output  81  assembled triangle {v0[80:54], v1[53:27], v2[26:0]}, 27-bit vertices as in proj_coor_in.
REQ-015 SHALL have port tri_valid_out / tri_ready_in  output / input  1 each  triangle ready/valid handshake.
REQ-016 SHALL have ports busy_out, obj_done_out, err_out  output  1 each  traversal active / end-of-object pulse / sticky protocol error.

Function
REQ-017 SHALL implement states IDLE, FETCH, ISSUE, WAIT, EMIT.
REQ-018 IDLE: start_in=1 -> vertex index vi=0, slot=0, mem_addr_out=0, FETCH; start_in outside IDLE SHALL be ignored.
REQ-019 FETCH: count MEM_LAT cycles from the address change; on the MEM_LAT-th cycle register mem_data_in into the request latch, go ISSUE.
REQ-020 ISSUE: proj_valid_out=1 for exactly one cycle; proj_obj_done_out=1 that cycle iff vi==NUM_VERTS-1; next state WAIT.
REQ-021 proj_coor_out SHALL be driven from the request latch and held stable from ISSUE until proj_valid_in is accepted.
REQ-022 WAIT: on proj_valid_in=1 store proj_coor_in into triangle slot `slot`; slot<2 -> slot+1, vi+1, mem_addr_out+1, FETCH; slot==2 -> EMIT.
REQ-023 EMIT: tri_valid_out=1, tri_out stable until the cycle tri_valid_out&&tri_ready_in.
REQ-024 On the EMIT handshake with vi<NUM_VERTS-1: slot=0, vi+1, mem_addr_out+1, FETCH.
REQ-025 On the EMIT handshake with vi==NUM_VERTS-1: obj_done_out=1 for one cycle, go IDLE.
REQ-026 busy_out SHALL be 1 in every state except IDLE.
REQ-027 Only one projector request SHALL be outstanding; no new proj_valid_out until the previous proj_valid_in.
REQ-028 proj_valid_in outside WAIT SHALL be discarded and set err_out; err_out clears only on reset.
REQ-029 vi and mem_addr_out SHALL never exceed NUM_VERTS-1; no wrap within one object.

Reset
REQ-030 rst_in=0 SHALL asynchronously force IDLE and clear vi, slot, mem_addr_out, proj_coor_out, proj_valid_out, proj_obj_done_out, tri_out, tri_valid_out, busy_out, obj_done_out, err_out to 0.
REQ-031 Reset mid-traversal SHALL abandon the object with no further strobes; the next start_in after release restarts at address 0.

Verification
REQ-032 NUM_VERTS=3, MEM_LAT=2, projector model replies 5 cycles after each request with {9'd10,9'd20,9'd30}, {11,21,31}, {12,22,32}, tri_ready_in=1 -> one tri_out = {10,20,30,11,21,31,12,22,32}, obj_done_out pulse, addresses 0,1,2 read, proj_obj_done_out only on the third request.
REQ-033 NUM_VERTS=6, tri_ready_in held 0 for 20 cycles at the first EMIT -> tri_out stable, no proj_valid_out until the handshake, then the second triangle completes normally.
REQ-034 start_in pulsed again during WAIT -> ignored; exactly NUM_VERTS proj_valid_out pulses per object.
REQ-035 proj_valid_in injected during FETCH -> err_out=1 and held; slot contents unchanged.
REQ-036 rst_in asserted during the second WAIT -> all outputs 0 immediately; after release and start_in, the first read is address 0.
REQ-037 Projector replies in the cycle immediately after the request -> accepted; proj_valid_out never high in two consecutive cycles.
